hazard_scoreboard_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_scoreboard_unit_if.sv | 49 ++++
 rtl/reg_scoreboard.sv | 56 +++++
 rtl/hazard_scoreboard_unit.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard/scoreboard unit.
package hazard_pkg;

   localparam logic [1:0] FWD_NONE        = 2'b00;
   localparam logic [1:0] FWD_WB          = 2'b01;
   localparam logic [1:0] FWD_MEM         = 2'b10;
   localparam logic [1:0] FWD_MDU         = 2'b11;
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // Individual hazard causes feeding the stall request.
   typedef struct packed {
      logic load;
      logic raw;
      logic waw;
      logic str;
   } hazard_t;

   // Youngest producer wins: MEM over WB over MDU writeback.
   function automatic logic [1:0] fwd_select(input logic hit_mem, input logic hit_wb,
                                             input logic hit_mdu);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (hit_mem) begin
         sel = FWD_MEM;
      end else if (hit_wb) begin
         sel = FWD_WB;
      end else if (hit_mdu) begin
         sel = FWD_MDU;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-to-hazard-unit bundle: stage addresses/controls in, stall/flush/forward out.
interface hazard_scoreboard_unit_if #(
   parameter int unsigned REG_WIDTH = 5
);
   logic [REG_WIDTH-1:0] i_rs1Addr_ID;
   logic [REG_WIDTH-1:0] i_rs2Addr_ID;
   logic [REG_WIDTH-1:0] i_rdAddr_ID;
   logic                 i_reg_write_ID;
   logic                 i_mdu_op_ID;
   logic [REG_WIDTH-1:0] i_rs1Addr_EX;
   logic [REG_WIDTH-1:0] i_rs2Addr_EX;
   logic [REG_WIDTH-1:0] i_rdAddr_EX;
   logic [1:0]           i_result_src_EX;
   logic                 i_pcSrc_EX;
   logic                 i_mdu_issue_EX;
   logic                 i_mdu_busy;
   logic [REG_WIDTH-1:0] i_rdAddr_M;
   logic                 i_reg_write_M;
   logic [REG_WIDTH-1:0] i_rdAddr_WB;
   logic                 i_reg_write_WB;
   logic                 i_mdu_wb_valid;
   logic [REG_WIDTH-1:0] i_mdu_wb_rd;

   logic                 o_stall_IF;
   logic                 o_stall_ID;
   logic                 o_flush_ID;
   logic                 o_flush_EX;
   logic [1:0]           o_forward_rs1_EX;
   logic [1:0]           o_forward_rs2_EX;
   logic                 o_hazard_err;

   modport master (
      output i_rs1Addr_ID, i_rs2Addr_ID, i_rdAddr_ID, i_reg_write_ID, i_mdu_op_ID,
             i_rs1Addr_EX, i_rs2Addr_EX, i_rdAddr_EX, i_result_src_EX, i_pcSrc_EX,
             i_mdu_issue_EX, i_mdu_busy, i_rdAddr_M, i_reg_write_M, i_rdAddr_WB,
             i_reg_write_WB, i_mdu_wb_valid, i_mdu_wb_rd,
      input  o_stall_IF, o_stall_ID, o_flush_ID, o_flush_EX, o_forward_rs1_EX,
             o_forward_rs2_EX, o_hazard_err
   );

   modport slave (
      input  i_rs1Addr_ID, i_rs2Addr_ID, i_rdAddr_ID, i_reg_write_ID, i_mdu_op_ID,
             i_rs1Addr_EX, i_rs2Addr_EX, i_rdAddr_EX, i_result_src_EX, i_pcSrc_EX,
             i_mdu_issue_EX, i_mdu_busy, i_rdAddr_M, i_reg_write_M, i_rdAddr_WB,
             i_reg_write_WB, i_mdu_wb_valid, i_mdu_wb_rd,
      output o_stall_IF, o_stall_ID, o_flush_ID, o_flush_EX, o_forward_rs1_EX,
             o_forward_rs2_EX, o_hazard_err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register for outstanding MDU results, with
// same-cycle issue bypass and write-first completion on the lookup ports.
module reg_scoreboard #(
   parameter int unsigned REG_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 set_en,
   input  logic [REG_WIDTH-1:0] set_addr,
   input  logic                 clr_en,
   input  logic [REG_WIDTH-1:0] clr_addr,
   input  logic [REG_WIDTH-1:0] lookup_a,
   input  logic [REG_WIDTH-1:0] lookup_b,
   input  logic [REG_WIDTH-1:0] lookup_c,
   output logic                 busy_a,
   output logic                 busy_b,
   output logic                 busy_c
);
   localparam int unsigned DEPTH = 1 << REG_WIDTH;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Clear first so a coincident set on the same entry wins; x0 never holds busy.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_addr] = 1'b0;
      end
      if (set_en && (set_addr != '0)) begin
         busy_d[set_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   function automatic logic eff_busy(input logic [REG_WIDTH-1:0] r);
      logic pend;
      pend = busy_q[r] | (set_en & (set_addr == r));
      return (r != '0) & pend & ~(clr_en & (clr_addr == r));
   endfunction

   always_comb begin
      busy_a = eff_busy(lookup_a);
      busy_b = eff_busy(lookup_b);
      busy_c = eff_busy(lookup_c);
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: forwarding, load-use/MDU stalls, branch flush.
// Optional stall watchdog enabled by defining HAZARD_WATCHDOG_EN.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_WIDTH     = 5,
   parameter int unsigned STALL_TIMEOUT = 64
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   hazard_scoreboard_unit_if.slave bus
);

   logic    busy_rs1;
   logic    busy_rs2;
   logic    busy_rd;
   hazard_t hz;
   logic    stall_req;
   logic    stall_id;

   if (STALL_TIMEOUT == 0) begin : g_bad_timeout
      $error("STALL_TIMEOUT must be non-zero");
   end

   reg_scoreboard #(
      .REG_WIDTH (REG_WIDTH)
   ) u_scoreboard (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .set_en   (bus.i_mdu_issue_EX),
      .set_addr (bus.i_rdAddr_EX),
      .clr_en   (bus.i_mdu_wb_valid),
      .clr_addr (bus.i_mdu_wb_rd),
      .lookup_a (bus.i_rs1Addr_ID),
      .lookup_b (bus.i_rs2Addr_ID),
      .lookup_c (bus.i_rdAddr_ID),
      .busy_a   (busy_rs1),
      .busy_b   (busy_rs2),
      .busy_c   (busy_rd)
   );

   always_comb begin
      hz.load   = (bus.i_result_src_EX == RESULT_SRC_LOAD) && (bus.i_rdAddr_EX != '0) &&
                  ((bus.i_rdAddr_EX == bus.i_rs1Addr_ID) || (bus.i_rdAddr_EX == bus.i_rs2Addr_ID));
      hz.raw    = busy_rs1 | busy_rs2;
      hz.waw    = bus.i_reg_write_ID & busy_rd;
      hz.str    = bus.i_mdu_op_ID & (bus.i_mdu_busy | bus.i_mdu_issue_EX);
      stall_req = |hz;
   end

   function automatic logic [1:0] fwd_for(input logic [REG_WIDTH-1:0] op);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (op != '0) begin
         sel = fwd_select(bus.i_reg_write_M  && (op == bus.i_rdAddr_M),
                          bus.i_reg_write_WB && (op == bus.i_rdAddr_WB),
                          bus.i_mdu_wb_valid && (op == bus.i_mdu_wb_rd));
      end
      return sel;
   endfunction

   // Defaults are the reset view: everything flushed, nothing stalled or forwarded.
   always_comb begin
      stall_id             = 1'b0;
      bus.o_stall_IF       = 1'b0;
      bus.o_flush_ID       = 1'b1;
      bus.o_flush_EX       = 1'b1;
      bus.o_forward_rs1_EX = FWD_NONE;
      bus.o_forward_rs2_EX = FWD_NONE;
      if (i_rst_n) begin
         bus.o_forward_rs1_EX = fwd_for(bus.i_rs1Addr_EX);
         bus.o_forward_rs2_EX = fwd_for(bus.i_rs2Addr_EX);
         if (!bus.i_pcSrc_EX) begin
            stall_id       = stall_req;
            bus.o_stall_IF = stall_req;
            bus.o_flush_ID = 1'b0;
            bus.o_flush_EX = stall_req;
         end
      end
   end

   assign bus.o_stall_ID = stall_id;

`ifdef HAZARD_WATCHDOG_EN
   localparam int unsigned   CNT_W   = $clog2(STALL_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] stall_cnt_d;
   logic             err_q;

   // Consecutive-stall counter, saturating at the timeout.
   always_comb begin
      stall_cnt_d = '0;
      if (stall_id) begin
         stall_cnt_d = (stall_cnt == CNT_MAX) ? CNT_MAX : stall_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         stall_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         stall_cnt <= stall_cnt_d;
         if (stall_cnt_d == CNT_MAX) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.o_hazard_err = err_q;
`else
   assign bus.o_hazard_err = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit against a behavioural model.
module tb_hazard_scoreboard_unit;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   bit   sb_m [32];

   hazard_scoreboard_unit_if #(.REG_WIDTH(5)) bus ();

   hazard_scoreboard_unit #(
      .REG_WIDTH     (5),
      .STALL_TIMEOUT (8)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] got_outs();
      return {bus.o_stall_IF, bus.o_stall_ID, bus.o_flush_ID, bus.o_flush_EX,
              bus.o_forward_rs1_EX, bus.o_forward_rs2_EX};
   endfunction

   // Register r has an MDU result still owed to the ID stage this cycle.
   function automatic bit pending(input logic [4:0] r);
      bit owed;
      if (r == 5'd0) return 1'b0;
      owed = sb_m[r] || (bus.i_mdu_issue_EX && bus.i_rdAddr_EX == r);
      if (bus.i_mdu_wb_valid && bus.i_mdu_wb_rd == r) owed = 1'b0;
      return owed;
   endfunction

   function automatic logic [1:0] fwd_m(input logic [4:0] a);
      if (a == 5'd0) return 2'b00;
      if (bus.i_reg_write_M && a == bus.i_rdAddr_M) return 2'b10;
      if (bus.i_reg_write_WB && a == bus.i_rdAddr_WB) return 2'b01;
      if (bus.i_mdu_wb_valid && a == bus.i_mdu_wb_rd) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [7:0] model_outs();
      bit stall;
      logic [1:0] f1, f2;
      if (!rst_n) return 8'b0011_0000;
      f1 = fwd_m(bus.i_rs1Addr_EX);
      f2 = fwd_m(bus.i_rs2Addr_EX);
      stall = (bus.i_result_src_EX == 2'b01 && bus.i_rdAddr_EX != 0 &&
               (bus.i_rdAddr_EX == bus.i_rs1Addr_ID || bus.i_rdAddr_EX == bus.i_rs2Addr_ID))
           || pending(bus.i_rs1Addr_ID) || pending(bus.i_rs2Addr_ID)
           || (bus.i_reg_write_ID && pending(bus.i_rdAddr_ID))
           || (bus.i_mdu_op_ID && (bus.i_mdu_busy || bus.i_mdu_issue_EX));
      if (bus.i_pcSrc_EX) return {2'b00, 2'b11, f1, f2};
      return {stall, stall, 1'b0, stall, f1, f2};
   endfunction

   task automatic idle();
      bus.i_rs1Addr_ID = '0; bus.i_rs2Addr_ID = '0; bus.i_rdAddr_ID = '0;
      bus.i_reg_write_ID = 0; bus.i_mdu_op_ID = 0;
      bus.i_rs1Addr_EX = '0; bus.i_rs2Addr_EX = '0; bus.i_rdAddr_EX = '0;
      bus.i_result_src_EX = 2'b00; bus.i_pcSrc_EX = 0;
      bus.i_mdu_issue_EX = 0; bus.i_mdu_busy = 0;
      bus.i_rdAddr_M = '0; bus.i_reg_write_M = 0;
      bus.i_rdAddr_WB = '0; bus.i_reg_write_WB = 0;
      bus.i_mdu_wb_valid = 0; bus.i_mdu_wb_rd = '0;
   endtask

   // Advance one clock, updating the model scoreboard as the edge does.
   task automatic tick();
      if (!rst_n) begin
         foreach (sb_m[i]) sb_m[i] = 1'b0;
      end else begin
         if (bus.i_mdu_wb_valid) sb_m[bus.i_mdu_wb_rd] = 1'b0;
         if (bus.i_mdu_issue_EX && bus.i_rdAddr_EX != 0) sb_m[bus.i_rdAddr_EX] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      rst_n = 0;
      bus.i_rs1Addr_ID = 5'd4; bus.i_rs1Addr_EX = 5'd4; bus.i_rdAddr_M = 5'd4;
      bus.i_reg_write_M = 1; bus.i_pcSrc_EX = 0; bus.i_mdu_op_ID = 1; bus.i_mdu_busy = 1;
      tick();
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b0011_0000) $display("FAIL reset_outs: got %b expected %b", got, 8'b0011_0000);
      else n_pass++;
      n_checks++;
      if (bus.o_hazard_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.o_hazard_err);
      else n_pass++;
      tick();
      rst_n = 1;
      idle();
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b0000_0000) $display("FAIL reset_idle: got %b expected %b", got, 8'b0);
      else n_pass++;
      tick();
   endtask

   task automatic test_load_use();
      logic [7:0] got;
      idle();
      bus.i_result_src_EX = 2'b01; bus.i_rdAddr_EX = 5'd5; bus.i_rs1Addr_ID = 5'd5;
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b1101_0000 || got !== model_outs())
         $display("FAIL load_use_stall: got %b expected %b", got, 8'b1101_0000);
      else n_pass++;
      tick();
      idle();
      bus.i_rs1Addr_EX = 5'd5; bus.i_rdAddr_WB = 5'd5; bus.i_reg_write_WB = 1;
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b0000_0100) $display("FAIL load_use_fwd: got %b expected %b", got, 8'b0000_0100);
      else n_pass++;
      tick();
   endtask

   task automatic test_mdu_raw();
      logic [7:0] got;
      for (int c = 0; c < 10; c++) begin
         idle();
         bus.i_rs1Addr_ID = 5'd7;
         if (c == 0) begin bus.i_mdu_issue_EX = 1; bus.i_rdAddr_EX = 5'd7; end
         #2;
         got = got_outs();
         n_checks++;
         if (got !== 8'b1101_0000)
            $display("FAIL mdu_raw_stall c%0d: got %b expected %b", c, got, 8'b1101_0000);
         else n_pass++;
         tick();
      end
      idle();
      bus.i_rs1Addr_ID = 5'd7; bus.i_rs1Addr_EX = 5'd7;
      bus.i_mdu_wb_valid = 1; bus.i_mdu_wb_rd = 5'd7;
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b0000_1100) $display("FAIL mdu_raw_release: got %b expected %b", got, 8'b0000_1100);
      else n_pass++;
      tick();
      idle();
      bus.i_rs1Addr_ID = 5'd7;
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b0000_0000) $display("FAIL mdu_raw_cleared: got %b expected %b", got, 8'b0);
      else n_pass++;
      tick();
   endtask

   task automatic test_set_clear();
      logic [7:0] got;
      logic [7:0] exp [4];
      exp = '{8'b0000_0000, 8'b1101_0000, 8'b0000_0000, 8'b0000_0000};
      for (int s = 0; s < 4; s++) begin
         idle();
         case (s)
            0: begin bus.i_mdu_issue_EX = 1; bus.i_rdAddr_EX = 5'd3;
                     bus.i_mdu_wb_valid = 1; bus.i_mdu_wb_rd = 5'd3; end
            1: bus.i_rs2Addr_ID = 5'd3;
            2: begin bus.i_rs2Addr_ID = 5'd3; bus.i_mdu_wb_valid = 1; bus.i_mdu_wb_rd = 5'd3; end
            default: bus.i_rs2Addr_ID = 5'd3;
         endcase
         #2;
         got = got_outs();
         n_checks++;
         if (got !== exp[s]) $display("FAIL set_clear s%0d: got %b expected %b", s, got, exp[s]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_branch();
      logic [7:0] got;
      idle();
      bus.i_mdu_issue_EX = 1; bus.i_rdAddr_EX = 5'd12;
      tick();
      idle();
      bus.i_rs1Addr_ID = 5'd12; bus.i_pcSrc_EX = 1;
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b0011_0000) $display("FAIL branch_flush: got %b expected %b", got, 8'b0011_0000);
      else n_pass++;
      tick();
      idle();
      bus.i_mdu_wb_valid = 1; bus.i_mdu_wb_rd = 5'd12;
      tick();
   endtask

   task automatic test_x0();
      logic [7:0] got;
      idle();
      bus.i_mdu_issue_EX = 1; bus.i_rdAddr_EX = 5'd0; bus.i_result_src_EX = 2'b01;
      bus.i_reg_write_ID = 1; bus.i_reg_write_M = 1; bus.i_rdAddr_M = 5'd0;
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b0000_0000) $display("FAIL x0_issue: got %b expected %b", got, 8'b0);
      else n_pass++;
      tick();
      idle();
      bus.i_reg_write_ID = 1; bus.i_reg_write_M = 1;
      #2;
      got = got_outs();
      n_checks++;
      if (got !== 8'b0000_0000) $display("FAIL x0_after: got %b expected %b", got, 8'b0);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      logic [7:0] got, exp;
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         bus.i_rs1Addr_ID = 5'($urandom_range(0, 7));
         bus.i_rs2Addr_ID = 5'($urandom_range(0, 7));
         bus.i_rdAddr_ID = 5'($urandom_range(0, 7));
         bus.i_reg_write_ID = 1'($urandom);
         bus.i_mdu_op_ID = ($urandom_range(0, 3) == 0);
         bus.i_rs1Addr_EX = 5'($urandom_range(0, 7));
         bus.i_rs2Addr_EX = 5'($urandom_range(0, 7));
         bus.i_rdAddr_EX = 5'($urandom_range(0, 7));
         bus.i_result_src_EX = 2'($urandom);
         bus.i_pcSrc_EX = ($urandom_range(0, 7) == 0);
         bus.i_mdu_issue_EX = ($urandom_range(0, 3) == 0);
         bus.i_mdu_busy = ($urandom_range(0, 3) == 0);
         bus.i_rdAddr_M = 5'($urandom_range(0, 7));
         bus.i_reg_write_M = 1'($urandom);
         bus.i_rdAddr_WB = 5'($urandom_range(0, 7));
         bus.i_reg_write_WB = 1'($urandom);
         bus.i_mdu_wb_valid = ($urandom_range(0, 2) == 0);
         bus.i_mdu_wb_rd = 5'($urandom_range(0, 7));
         #2;
         got = got_outs();
         exp = model_outs();
         n_checks++;
         if (got !== exp) $display("FAIL random c%0d: got %b expected %b", c, got, exp);
         else n_pass++;
         tick();
      end
      rst_n = 0;
      idle();
      tick();
      rst_n = 1;
   endtask

   task automatic test_watchdog();
      bit exp_err;
      rst_n = 0;
      idle();
      tick();
      rst_n = 1;
      bus.i_mdu_issue_EX = 1; bus.i_rdAddr_EX = 5'd9;
      tick();
      idle();
      bus.i_rs1Addr_ID = 5'd9;
      for (int c = 1; c <= 10; c++) begin
         tick();
`ifdef HAZARD_WATCHDOG_EN
         exp_err = (c >= 8);
`else
         exp_err = 1'b0;
`endif
         n_checks++;
         if (bus.o_hazard_err !== exp_err)
            $display("FAIL watchdog c%0d: got %b expected %b", c, bus.o_hazard_err, exp_err);
         else n_pass++;
      end
      bus.i_rs1Addr_ID = 5'd0;
      tick();
      tick();
`ifdef HAZARD_WATCHDOG_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      n_checks++;
      if (bus.o_hazard_err !== exp_err)
         $display("FAIL watchdog_sticky: got %b expected %b", bus.o_hazard_err, exp_err);
      else n_pass++;
      rst_n = 0;
      tick();
      n_checks++;
      if (bus.o_hazard_err !== 1'b0) $display("FAIL watchdog_reset: got %b expected 0", bus.o_hazard_err);
      else n_pass++;
      rst_n = 1;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      foreach (sb_m[i]) sb_m[i] = 1'b0;
      rst_n = 0;
      idle();
      #1;
      test_reset();
      test_load_use();
      test_mdu_raw();
      test_set_clear();
      test_branch();
      test_x0();
      test_random();
      test_watchdog();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
